// File: rtl/mat_pkg.sv
// Shared types for the matrix cache controller: opcodes, FSM states
// and requester count.
package mat_pkg;

   localparam int NUM_REQ       = 2;
   localparam int DIAG_SIZE_DEF = 8;

   typedef enum logic [1:0] {
      OP_NOP       = 2'b00,
      OP_READ      = 2'b01,
      OP_WRITE     = 2'b10,
      OP_TRANSPOSE = 2'b11
   } mat_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TRANSPOSE,
      ST_TP_WAIT
   } mat_state_e;

endpackage

// File: rtl/mat_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer names the favoured requester
// and moves past whoever was granted.
module mat_rr_arbiter
   import mat_pkg::*;
(
   input  logic               clock,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt
);

   logic ptr_q, ptr_d;

   always_comb begin
      gnt   = req;
      ptr_d = ptr_q;
      if (&req) begin
         gnt        = '0;
         gnt[ptr_q] = 1'b1;
      end
      if (|gnt) ptr_d = gnt[0];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) ptr_q <= 1'b0;
      else          ptr_q <= ptr_d;
   end

endmodule

// File: rtl/mat_cache_ctrl.sv
// Matrix cache controller: arbitrates two requesters onto one cache port,
// tracks in-flight reads and serialises transposes behind a barrier.
module mat_cache_ctrl
   import mat_pkg::*;
#(
   parameter int CACHE_SIZE      = 4,
   parameter int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE),
   parameter int DIAG_SIZE       = DIAG_SIZE_DEF,
   parameter int READ_LATENCY    = 1
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic [1:0]                      req_valid,
   output logic [1:0]                      req_ready,
   input  logic [1:0][1:0]                 req_op,
   input  logic [1:0][CACHE_ADDR_SIZE-1:0] req_addr,
   input  logic [1:0][DIAG_SIZE-1:0]       req_diag,
   output logic                            read_enable,
   output logic                            write_enable,
   output logic                            transpose_enable,
   output logic [CACHE_ADDR_SIZE-1:0]      cache_addr,
   output logic [DIAG_SIZE-1:0]            cache_diag,
   output logic                            rsp_valid,
   output logic                            rsp_id
);

   localparam int RL = READ_LATENCY;

   mat_state_e state_q, state_d;
   logic rd_q, rd_d, wr_q, wr_d, tp_q, tp_d;
   logic [CACHE_ADDR_SIZE-1:0] addr_q, addr_d;
   logic [DIAG_SIZE-1:0] diag_q, diag_d;
   logic rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
   logic [RL-1:0] pv_q, pv_d, pid_q, pid_d;
   logic [RL-1:0][CACHE_ADDR_SIZE-1:0] pa_q, pa_d;

   logic [1:0] tp_hit, elig, gnt;
   logic       xfer, gsel;
   mat_op_e    sel_op;

   always_comb begin
      tp_hit = '0;
      elig   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         for (int k = 0; k < RL; k++)
            if (pv_q[k] && pa_q[k] == req_addr[i]) tp_hit[i] = 1'b1;
         elig[i] = req_valid[i] && state_q == ST_IDLE &&
                   !(mat_op_e'(req_op[i]) == OP_TRANSPOSE && tp_hit[i]);
      end
   end

   mat_rr_arbiter u_arb (
      .clock   (clock),
      .reset_n (reset_n),
      .req     (elig),
      .gnt     (gnt)
   );

   assign req_ready = gnt & {2{reset_n}};
   assign xfer      = |req_ready;
   assign gsel      = gnt[1];
   assign sel_op    = mat_op_e'(req_op[gsel]);

   always_comb begin
      state_d = state_q;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      tp_d    = 1'b0;
      addr_d  = addr_q;
      diag_d  = diag_q;
      unique case (state_q)
         ST_IDLE:
            if (xfer && sel_op == OP_TRANSPOSE) state_d = ST_TRANSPOSE;
         ST_TRANSPOSE: state_d = ST_TP_WAIT;
         ST_TP_WAIT:   state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
      if (xfer) begin
         unique case (sel_op)
            OP_READ:      rd_d = 1'b1;
            OP_WRITE:     wr_d = 1'b1;
            OP_TRANSPOSE: tp_d = 1'b1;
            default:      ;
         endcase
         if (sel_op != OP_NOP) begin
            addr_d = req_addr[gsel];
            diag_d = req_diag[gsel];
         end
      end
   end

   // Read tracker: entry k is live k cycles after its strobe.
   always_comb begin
      pv_d  = '0;
      pid_d = '0;
      pa_d  = '0;
      for (int k = RL - 1; k > 0; k--) begin
         pv_d[k]  = pv_q[k-1];
         pid_d[k] = pid_q[k-1];
         pa_d[k]  = pa_q[k-1];
      end
      pv_d[0]     = rd_d;
      pid_d[0]    = gsel;
      pa_d[0]     = req_addr[gsel];
      rsp_valid_d = pv_q[RL-1];
      rsp_id_d    = pv_q[RL-1] ? pid_q[RL-1] : rsp_id_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         tp_q        <= 1'b0;
         addr_q      <= '0;
         diag_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         pv_q        <= '0;
         pid_q       <= '0;
         pa_q        <= '0;
      end else begin
         state_q     <= state_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         tp_q        <= tp_d;
         addr_q      <= addr_d;
         diag_q      <= diag_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         pv_q        <= pv_d;
         pid_q       <= pid_d;
         pa_q        <= pa_d;
      end
   end

   assign read_enable      = rd_q;
   assign write_enable     = wr_q;
   assign transpose_enable = tp_q;
   assign cache_addr       = addr_q;
   assign cache_diag       = diag_q;
   assign rsp_valid        = rsp_valid_q;
   assign rsp_id           = rsp_id_q;

endmodule

// File: tb/tb_mat_cache_ctrl.sv
// Random and directed stimulus for mat_cache_ctrl, checked each cycle
// against a transaction-level model of grants, strobes and responses.
module tb_mat_cache_ctrl;

   localparam int RL = 3;

   logic             clock = 1'b0;
   logic             reset_n;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0][1:0]  req_op;
   logic [1:0][1:0]  req_addr;
   logic [1:0][7:0]  req_diag;
   logic             read_enable, write_enable, transpose_enable;
   logic [1:0]       cache_addr;
   logic [7:0]       cache_diag;
   logic             rsp_valid, rsp_id;

   mat_cache_ctrl #(
      .CACHE_SIZE   (4),
      .READ_LATENCY (RL)
   ) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_op           (req_op),
      .req_addr         (req_addr),
      .req_diag         (req_diag),
      .read_enable      (read_enable),
      .write_enable     (write_enable),
      .transpose_enable (transpose_enable),
      .cache_addr       (cache_addr),
      .cache_diag       (cache_diag),
      .rsp_valid        (rsp_valid),
      .rsp_id           (rsp_id)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int t;
      int id;
      int a;
   } rd_t;

   rd_t rq[$];
   int  cyc        = 0;
   int  busy_until = 0;
   int  last       = 1;
   logic e_rd, e_wr, e_tp;
   logic [1:0] e_addr;
   logic [7:0] e_diag;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   function automatic bit slot_busy(input int a);
      foreach (rq[j])
         if (rq[j].a == a && cyc < rq[j].t) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      rq.delete();
      busy_until = 0;
      last       = 1;
      e_rd       = 1'b0;
      e_wr       = 1'b0;
      e_tp       = 1'b0;
      e_addr     = '0;
      e_diag     = '0;
   endtask

   task automatic step(input logic [1:0] v,
                       input logic [1:0] op0, input logic [1:0] a0,
                       input logic [7:0] d0,
                       input logic [1:0] op1, input logic [1:0] a1,
                       input logic [7:0] d1,
                       output logic [1:0] g);
      logic [1:0] el, eg;
      logic [1:0] op[2];
      logic [1:0] ad[2];
      logic [7:0] dg[2];
      logic ev;
      int   eid, k;
      op[0] = op0; op[1] = op1;
      ad[0] = a0;  ad[1] = a1;
      dg[0] = d0;  dg[1] = d1;
      req_valid   = v;
      req_op[0]   = op0;
      req_op[1]   = op1;
      req_addr[0] = a0;
      req_addr[1] = a1;
      req_diag[0] = d0;
      req_diag[1] = d1;
      @(negedge clock);
      for (int i = 0; i < 2; i++)
         el[i] = v[i] && cyc >= busy_until &&
                 !(op[i] == 2'd3 && slot_busy(int'(ad[i])));
      if (el == 2'b11) eg = (last == 1) ? 2'b01 : 2'b10;
      else             eg = el;
      chk("req_ready", 32'(req_ready), 32'(eg));
      chk("read_enable", 32'(read_enable), 32'(e_rd));
      chk("write_enable", 32'(write_enable), 32'(e_wr));
      chk("transpose_enable", 32'(transpose_enable), 32'(e_tp));
      chk("cache_addr", 32'(cache_addr), 32'(e_addr));
      chk("cache_diag", 32'(cache_diag), 32'(e_diag));
      ev  = 1'b0;
      eid = 0;
      if (rq.size() > 0 && rq[0].t == cyc) begin
         ev  = 1'b1;
         eid = rq[0].id;
         void'(rq.pop_front());
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev) chk("rsp_id", 32'(rsp_id), 32'(eid));
      e_rd = 1'b0;
      e_wr = 1'b0;
      e_tp = 1'b0;
      if (eg != 2'b00) begin
         k    = eg[1] ? 1 : 0;
         last = k;
         case (op[k])
            2'd1: begin
               e_rd = 1'b1;
               rq.push_back('{t: cyc + 1 + RL, id: k, a: int'(ad[k])});
            end
            2'd2: e_wr = 1'b1;
            2'd3: begin
               e_tp       = 1'b1;
               busy_until = cyc + 3;
            end
            default: ;
         endcase
         if (op[k] != 2'd0) begin
            e_addr = ad[k];
            e_diag = dg[k];
         end
      end
      g = req_ready;
      cyc++;
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      logic [1:0] g;
      repeat (n) step(2'b00, 2'd0, 2'd0, 8'd0, 2'd0, 2'd0, 8'd0, g);
   endtask

   task automatic do_reset();
      req_valid = 2'b11;
      req_op[0] = 2'd1;
      req_op[1] = 2'd1;
      reset_n   = 1'b0;
      #1;
      chk("rst_read_enable", 32'(read_enable), 32'd0);
      chk("rst_write_enable", 32'(write_enable), 32'd0);
      chk("rst_transpose_enable", 32'(transpose_enable), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_cache_addr", 32'(cache_addr), 32'd0);
      chk("rst_cache_diag", 32'(cache_diag), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      req_valid = 2'b00;
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      @(posedge clock);
      #1;
      cyc += 2;
   endtask

   initial begin
      logic [1:0] g;
      int t0, tacc;
      req_valid = '0;
      req_op    = '0;
      req_addr  = '0;
      req_diag  = '0;
      reset_n   = 1'b1;
      model_reset();
      #2;
      do_reset();

      // Both read from reset: req0 then req1, responses in order
      step(2'b11, 2'd1, 2'd1, 8'd0, 2'd1, 2'd2, 8'd0, g);
      chk("rr_first", 32'(g), 32'd1);
      step(2'b10, 2'd1, 2'd1, 8'd0, 2'd1, 2'd2, 8'd0, g);
      chk("rr_second", 32'(g), 32'd2);
      idle(RL + 2);

      step(2'b01, 2'd2, 2'd3, 8'd5, 2'd0, 2'd0, 8'd0, g);
      idle(3);

      step(2'b01, 2'd3, 2'd0, 8'd9, 2'd0, 2'd0, 8'd0, g);
      step(2'b11, 2'd1, 2'd1, 8'd1, 2'd1, 2'd2, 8'd2, g);
      step(2'b11, 2'd1, 2'd1, 8'd1, 2'd1, 2'd2, 8'd2, g);
      step(2'b11, 2'd1, 2'd1, 8'd1, 2'd1, 2'd2, 8'd2, g);
      chk("tp_barrier_release", 32'(g != 2'b00), 32'd1);
      idle(RL + 2);

      // Transpose on a slot with a read outstanding is held off
      step(2'b01, 2'd1, 2'd2, 8'd0, 2'd0, 2'd0, 8'd0, g);
      t0 = cyc - 1;
      step(2'b11, 2'd2, 2'd1, 8'd7, 2'd3, 2'd2, 8'd3, g);
      chk("write_over_tp", 32'(g), 32'd1);
      tacc = -1;
      for (int i = 0; i < 10 && tacc < 0; i++) begin
         step(2'b10, 2'd0, 2'd0, 8'd0, 2'd3, 2'd2, 8'd3, g);
         if (g[1]) tacc = cyc - 1;
      end
      chk("tp_hold", 32'(tacc - t0), 32'(1 + RL));
      idle(4);

      // Reset during the barrier with a read in flight
      step(2'b01, 2'd1, 2'd1, 8'd0, 2'd0, 2'd0, 8'd0, g);
      step(2'b10, 2'd0, 2'd0, 8'd0, 2'd3, 2'd0, 8'd4, g);
      idle(1);
      do_reset();
      step(2'b11, 2'd2, 2'd0, 8'd1, 2'd2, 2'd1, 8'd2, g);
      chk("post_reset_grant", 32'(g), 32'd1);
      idle(RL + 2);

      for (int n = 0; n < 400; n++) begin
         step(2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              8'($urandom_range(0, 255)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              8'($urandom_range(0, 255)), g);
         if (n == 200) do_reset();
      end
      idle(RL + 3);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mat_cache_ctrl.md
MAT_CACHE_CTRL -- requirements
Module: mat_cache_ctrl

Interface
REQ-001 SHALL have parameter CACHE_SIZE, default 4, number of matrix slots in the cache.
REQ-002 SHALL have parameter CACHE_ADDR_SIZE, default $clog2(CACHE_SIZE), slot address width.
REQ-003 SHALL have parameter DIAG_SIZE, default 8, diagonal index width (1+$clog2(WIDTH), WIDTH=128).
REQ-004 SHALL have parameter READ_LATENCY, default 1, cache strobe-to-data cycles; legal range 1..4.
REQ-005 SHALL have port clock, input, 1, single clock, rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, [1:0], command valid per requester.
REQ-008 SHALL have port req_ready, output, [1:0], command accepted per requester.
REQ-009 SHALL have port req_op, input, [1:0][1:0], opcode per requester: 00 NOP, 01 READ, 10 WRITE, 11 TRANSPOSE.
REQ-010 SHALL have port req_addr, input, [1:0][CACHE_ADDR_SIZE-1:0], slot per requester.
REQ-011 SHALL have port req_diag, input, [1:0][DIAG_SIZE-1:0], diagonal per requester.
REQ-012 SHALL have ports read_enable, write_enable and transpose_enable, output, 1 each, cache strobes.
REQ-013 SHALL have ports cache_addr, output, CACHE_ADDR_SIZE, and cache_diag, output, DIAG_SIZE, shared slot/diagonal for read, write and transpose.
REQ-014 SHALL have port rsp_valid, output, 1, read data valid at the cache output this cycle.
REQ-015 SHALL have port rsp_id, output, 1, requester owning the rsp_valid data.

Function
REQ-016 Handshake: a command SHALL transfer when req_valid[i] and req_ready[i] are both high; at most one req_ready bit SHALL be high per cycle; req_ready SHALL be a function of state and inputs only, with no dependence on outputs of the same cycle.
REQ-017 Arbitration SHALL be round-robin: when both requesters are eligible, grant the requester not granted last; the pointer SHALL update only on a transfer.
REQ-018 A command accepted in cycle N SHALL drive exactly one strobe with cache_addr/cache_diag in cycle N+1; all outputs SHALL be registered.
REQ-019 A NOP SHALL be accepted and SHALL produce no strobe.
REQ-020 READ strobed in cycle M SHALL assert rsp_valid with rsp_id = requester in cycle M+READ_LATENCY, via an in-flight shift register; back-to-back reads SHALL give back-to-back responses.
REQ-021 FSM SHALL have states IDLE, TRANSPOSE and TP_WAIT: IDLE accepts any eligible command; an accepted TRANSPOSE moves IDLE->TRANSPOSE (transpose_enable high one cycle) ->TP_WAIT (one barrier cycle) ->IDLE.
REQ-022 In TRANSPOSE and TP_WAIT, req_ready SHALL be 0 for both requesters.
REQ-023 A TRANSPOSE to slot X SHALL be ineligible while any in-flight read targets slot X; the other requester SHALL be granted if it is eligible.
REQ-024 A READ or WRITE SHALL remain eligible during an in-flight read to any slot.
REQ-025 Idle outputs: when no strobe is issued, the strobes SHALL be 0 and cache_addr/cache_diag SHALL hold their last value.

Reset
REQ-026 Assertion of reset_n low SHALL asynchronously set: FSM to IDLE, all strobes 0, req_ready 0, rsp_valid 0, rsp_id 0, cache_addr 0, cache_diag 0, the round-robin pointer to favour requester 0, and the in-flight reads cleared.
REQ-027 Reset mid-transpose or with reads in flight SHALL drop them with no response; the first grant SHALL be possible in the first cycle after deassertion.

Structure
REQ-028 Opcode enum, requester count (2) and the default DIAG_SIZE SHALL live in shared package mat_pkg.
REQ-029 The round-robin arbiter SHALL be the sub-module mat_rr_arbiter (request vector in, one-hot grant out, pointer internal).

Verification
REQ-030 Both requesters issue READ slot 1 / READ slot 2 from reset -> req0 granted first, then req1; read_enable in cycles N+1 and N+2; rsp_valid in cycles N+2 (id 0) and N+3 (id 1) at READ_LATENCY=1.
REQ-031 WRITE slot 3 diag 5 -> write_enable pulse one cycle with cache_addr=3 and cache_diag=5, no rsp_valid.
REQ-032 TRANSPOSE slot 0 accepted in cycle N -> transpose_enable high in N+1, req_ready 0 in N+1 and N+2, next grant possible in N+3.
REQ-033 READ_LATENCY=3, req0 READ slot 2, then req1 TRANSPOSE slot 2 and req0 WRITE slot 1 -> WRITE granted, TRANSPOSE held until the read response, then granted.
REQ-034 reset_n pulsed low during TP_WAIT with a read in flight -> all outputs 0 immediately, no rsp_valid afterwards, req0 granted first after release.
